// File: rtl/fd_stage_buf_if.sv
// Valid/ready payload bus used on both sides of the fetch-to-decode stage buffer.
// The master drives valid/data and the slave drives ready.
interface fd_stage_buf_if #(
    parameter int PAYLOAD_W = 131
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fd_stage_buf.sv
// Fetch-to-decode stage buffer: main entry plus one skid entry, so fetch sees a
// registered ready; flush turns in-flight entries into bubbles; stall cycles are counted.
module fd_stage_buf #(
    parameter int                   PAYLOAD_W   = 131,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
    parameter int                   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    fd_stage_buf_if.slave    in_if,
    fd_stage_buf_if.master   out_if,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic                 out_valid_p1;
    logic [PAYLOAD_W-1:0] out_data_p1;
    logic                 skid_valid_p1;
    logic [PAYLOAD_W-1:0] skid_data_p1;
    logic                 in_fire_p0;
    logic                 main_free_p0;
    logic                 skid_load_p0;

    // ready depends only on a flop, so decode back-pressure never reaches fetch combinationally
    assign in_if.ready  = ~skid_valid_p1;
    assign in_fire_p0   = in_if.valid & ~skid_valid_p1;
    assign main_free_p0 = ~out_valid_p1 | out_if.ready;
    assign skid_load_p0 = ~flush & ~main_free_p0 & in_fire_p0;

    // ---- stage p0 -> p1: main and skid entries ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_p1  <= 1'b0;
            out_data_p1   <= NOP_PAYLOAD;
            skid_valid_p1 <= 1'b0;
        end else if (flush) begin
            out_valid_p1  <= 1'b0;
            out_data_p1   <= NOP_PAYLOAD;
            skid_valid_p1 <= 1'b0;
        end else if (main_free_p0) begin
            if (skid_valid_p1) begin
                out_valid_p1  <= 1'b1;
                out_data_p1   <= skid_data_p1;
                skid_valid_p1 <= 1'b0;
            end else if (in_fire_p0) begin
                out_valid_p1 <= 1'b1;
                out_data_p1  <= in_if.data;
            end else begin
                out_valid_p1 <= 1'b0;
                out_data_p1  <= NOP_PAYLOAD;
            end
        end else if (in_fire_p0) begin
            skid_valid_p1 <= 1'b1;
        end
    end

    // skid payload is only ever read while skid_valid_p1 is set, so it needs no reset
    always_ff @(posedge clk) begin
        if (skid_load_p0) begin
            skid_data_p1 <= in_if.data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid_p1 && !out_if.ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign out_if.valid = out_valid_p1;
    assign out_if.data  = out_data_p1;
    assign occ          = {1'b0, out_valid_p1} + {1'b0, skid_valid_p1};

endmodule

// File: tb/tb_fd_stage_buf.sv
// Directed and scoreboarded random checks for fd_stage_buf (main instance CNT_W=16,
// second instance CNT_W=4 for counter saturation).
module tb_fd_stage_buf;
    localparam int PW = 131;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    fd_stage_buf_if #(.PAYLOAD_W(PW)) a_in ();
    fd_stage_buf_if #(.PAYLOAD_W(PW)) a_out ();
    fd_stage_buf_if #(.PAYLOAD_W(PW)) b_in ();
    fd_stage_buf_if #(.PAYLOAD_W(PW)) b_out ();

    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    fd_stage_buf #(.PAYLOAD_W(PW), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_if(a_in), .out_if(a_out), .occ(a_occ), .stall_cnt(a_cnt)
    );

    fd_stage_buf #(.PAYLOAD_W(PW), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_if(b_in), .out_if(b_out), .occ(b_occ), .stall_cnt(b_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [PW-1:0] q[$];
    logic [PW-1:0] pay;
    logic [PW-1:0] exp_data;
    logic [15:0]   m_cnt;
    logic          acc;

    initial begin
        a_in.valid  = 1'b0;
        a_in.data   = '0;
        a_out.ready = 1'b1;
        b_in.valid  = 1'b0;
        b_in.data   = '0;
        b_out.ready = 1'b1;

        // reset values, no clock edge needed
        #2;
        chk("rst_vld",   160'(a_out.valid), 160'(0));
        chk("rst_data",  160'(a_out.data),  160'(0));
        chk("rst_rdy",   160'(a_in.ready),  160'(1));
        chk("rst_occ",   160'(a_occ),       160'(0));
        chk("rst_cnt",   160'(a_cnt),       160'(0));
        #10 rst = 1'b1;

        // streaming at full throughput
        for (int i = 1; i <= 8; i++) begin
            a_in.valid = 1'b1;
            a_in.data  = PW'(i);
            tick();
            chk("strm_vld",  160'(a_out.valid), 160'(1));
            chk("strm_data", 160'(a_out.data),  160'(i));
            chk("strm_occ",  160'(a_occ),       160'(1));
        end
        a_in.valid = 1'b0;
        tick();
        chk("strm_end_vld",  160'(a_out.valid), 160'(0));
        chk("strm_end_data", 160'(a_out.data),  160'(0));
        chk("strm_cnt",      160'(a_cnt),       160'(0));

        // back-pressure: A held, B in skid, C waits upstream
        a_in.valid = 1'b1; a_in.data = PW'(32'hA); a_out.ready = 1'b1;
        tick();
        chk("bp_a_vld", 160'(a_out.valid), 160'(1));
        a_in.data = PW'(32'hB); a_out.ready = 1'b0;
        tick();
        chk("bp_full_occ", 160'(a_occ),      160'(2));
        chk("bp_full_rdy", 160'(a_in.ready), 160'(0));
        chk("bp_hold_a",   160'(a_out.data), 160'(32'hA));
        a_in.data = PW'(32'hC);
        tick();
        tick();
        chk("bp_still_a",   160'(a_out.data), 160'(32'hA));
        chk("bp_still_occ", 160'(a_occ),      160'(2));
        a_out.ready = 1'b1;
        tick();
        chk("bp_b",     160'(a_out.data), 160'(32'hB));
        chk("bp_b_occ", 160'(a_occ),      160'(1));
        chk("bp_b_rdy", 160'(a_in.ready), 160'(1));
        tick();
        chk("bp_c", 160'(a_out.data), 160'(32'hC));
        a_in.valid = 1'b0;
        tick();
        chk("bp_empty", 160'(a_out.valid), 160'(0));
        chk("bp_cnt",   160'(a_cnt),       160'(3));

        // flush with occ=2 and a payload offered in the same cycle
        a_in.valid = 1'b1; a_in.data = PW'(32'hD1); a_out.ready = 1'b1;
        tick();
        a_in.data = PW'(32'hD2); a_out.ready = 1'b0;
        tick();
        chk("fl_pre_occ", 160'(a_occ), 160'(2));
        flush = 1'b1; a_in.data = PW'(32'hD);
        tick();
        chk("fl_vld",  160'(a_out.valid), 160'(0));
        chk("fl_data", 160'(a_out.data),  160'(0));
        chk("fl_occ",  160'(a_occ),       160'(0));
        chk("fl_rdy",  160'(a_in.ready),  160'(1));
        flush = 1'b0; a_in.valid = 1'b0; a_out.ready = 1'b1;
        tick();
        chk("fl_no_d", 160'(a_out.valid), 160'(0));
        chk("fl_cnt",  160'(a_cnt),       160'(5));

        // stall counter saturation on the CNT_W=4 instance
        b_in.valid = 1'b1; b_in.data = PW'(32'h55); b_out.ready = 1'b0;
        tick();
        b_in.valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14) chk("sat_cnt14", 160'(b_cnt), 160'(14));
        end
        chk("sat_cnt", 160'(b_cnt),      160'(15));
        chk("sat_hold", 160'(b_out.data), 160'(32'h55));

        // asynchronous reset while full
        a_in.valid = 1'b1; a_in.data = PW'(32'h11); a_out.ready = 1'b1;
        tick();
        a_in.data = PW'(32'h22); a_out.ready = 1'b0;
        tick();
        chk("ar_pre_occ", 160'(a_occ), 160'(2));
        #2 rst = 1'b0;
        #1;
        chk("ar_vld",  160'(a_out.valid), 160'(0));
        chk("ar_data", 160'(a_out.data),  160'(0));
        chk("ar_occ",  160'(a_occ),       160'(0));
        chk("ar_rdy",  160'(a_in.ready),  160'(1));
        chk("ar_cnt",  160'(a_cnt),       160'(0));
        a_in.valid = 1'b0;
        #2 rst = 1'b1;
        a_in.valid = 1'b1; a_in.data = PW'(32'hAA); a_out.ready = 1'b1;
        tick();
        chk("ar_aa",     160'(a_out.data), 160'(32'hAA));
        chk("ar_aa_occ", 160'(a_occ),      160'(1));
        a_in.valid = 1'b0;
        tick();
        chk("ar_alone", 160'(a_out.valid), 160'(0));

        // random traffic against a 2-deep FIFO model
        m_cnt = '0;
        for (int i = 0; i < 10000; i++) begin
            flush       = ($urandom_range(0, 31) == 0);
            a_in.valid  = ($urandom_range(0, 2) != 0);
            a_out.ready = 1'($urandom_range(0, 1));
            pay = {3'(i), $urandom(), $urandom(), $urandom(), 32'(i)};
            a_in.data = pay;
            if (q.size() > 0 && !a_out.ready && m_cnt != 16'hFFFF) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                acc = a_in.valid && (q.size() < 2);
                if (q.size() > 0 && a_out.ready) void'(q.pop_front());
                if (acc) q.push_back(pay);
            end
            tick();
            exp_data = (q.size() > 0) ? q[0] : '0;
            chk("rnd_vld",  160'(a_out.valid), 160'(q.size() > 0));
            chk("rnd_data", 160'(a_out.data),  160'(exp_data));
            chk("rnd_occ",  160'(a_occ),       160'(q.size()));
            chk("rnd_rdy",  160'(a_in.ready),  160'(q.size() < 2));
            chk("rnd_cnt",  160'(a_cnt),       160'(m_cnt));
        end
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
